register_multi_in: RTL and testbench
====================================

# register_multi_in

Parametrised multi-source register for the 6502 datapath, replacing the fixed two-input register used for the B input and the program counter select registers. It captures one of NUM_IN input buses per clock using fixed or lock-on-first arbitration, and can increment or decrement in place with a chainable carry. Two 8-bit instances form the 16-bit PC. All state is clocked on clk, not on load edges.

## Interface
- WIDTH, 8, data width in bits
- NUM_IN, 2, number of input channels (≥1)
- LOCK_MODE, 0, 0 = fixed priority every cycle; 1 = first winner holds ownership until it releases
- RESET_VALUE, '0, data_out value after reset
- SRC_W, derived: $clog2(NUM_IN), minimum 1
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data_in  in  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- load  in  NUM_IN  per-channel load request
- inc  in  1  add carry_in to data_out when no load wins
- dec  in  1  subtract carry_in from data_out when no load wins
- carry_in  in  1  increment/decrement amount (tie to 1 on low half, to low half's carry_out on high half)
- clear_conflict  in  1  clears the sticky conflict flag
- data_out  out  WIDTH  register contents
- carry_out  out  1  registered carry/borrow from last inc/dec
- src  out  SRC_W  index of channel that performed the last load
- valid  out  1  high once any load has occurred since reset
- conflict  out  1  sticky arbitration/command conflict flag

## Operation
- Reset (rst_n low at a clk edge): data_out=RESET_VALUE, carry_out=0, src=0, valid=0, conflict=0, arbiter state IDLE. Reset overrides all inputs.
- Priority: lowest asserted index wins (channel 0 highest), matching the legacy load0-over-load1 rule.
- LOCK_MODE=0: each cycle with any load asserted, the winner's data is captured; src=winner, valid=1.
- LOCK_MODE=1, states IDLE and HELD(owner):
  - IDLE: any load asserted → capture the winner, go to HELD(winner).
  - HELD(k), load[k]=1: capture channel k every cycle; all other loads ignored, including higher-priority ones (generalises the legacy "load0 transition ignored while load1 active").
  - HELD(k), load[k]=0: behave as IDLE in the same cycle. Arbitrate the remaining loads; with no loads, return to IDLE.
- No winning load, inc=1, dec=0: {carry_out,data_out} ← data_out + carry_in, with width WIDTH+1 and wrap at 2^WIDTH.
- No winning load, dec=1, inc=0: data_out ← data_out − carry_in; carry_out=1 on borrow (0 → all-ones with carry_in=1).
- Any cycle without an inc/dec update, including load cycles: carry_out ← 0.
- inc=dec=1 with no load: data_out holds and carry_out ← 0.
- A winning load beats inc/dec.
- conflict is set by any of:
  - ≥2 loads asserted in one cycle in LOCK_MODE=0;
  - a non-owner load ignored in HELD;
  - inc=dec=1.
- conflict is cleared by clear_conflict. A set condition in the same cycle wins over the clear.

## Timing
- All outputs are registered. Inputs sampled at edge n appear on the outputs after edge n, giving 1-cycle latency with no combinational input→output paths.
- Chained PC: the high half sees the low half's carry_out one cycle late, so the high byte updates the cycle after the low byte wraps. The CPU sequencer accounts for this extra cycle.
- Reset asserted mid-HELD abandons ownership. The first post-reset cycle arbitrates from IDLE.
- NUM_IN=1: arbitration degenerates, src constant 0, and LOCK_MODE has no effect beyond conflict on inc=dec.

## Structure
- Package reg_multi_pkg:
  - arbiter state enum {ARB_IDLE, ARB_HELD};
  - function lowest_set_index(vector) returning index and found flag.
- One sub-module, prio_onehot: parametrised lowest-index-first priority encoder (NUM_IN in, one-hot grant plus SRC_W index plus any-bit out). It is reused by other multi-source datapath registers.
- Top level: arbiter state/owner registers, capture mux, inc/dec adder of width WIDTH+1, conflict logic.

## Test plan
- Reset: RESET_VALUE=8'hA5, drive loads during rst_n=0 → data_out=8'hA5, valid=0, conflict=0. Release with load[1]=1, data 8'h3C → next cycle data_out=8'h3C, src=1, valid=1.
- Priority (LOCK_MODE=0, NUM_IN=4): load=4'b1010, ch1=8'h11, ch3=8'h33 → data_out=8'h11, src=1, conflict=1. Pulse clear_conflict → conflict=0.
- Lock sequence (LOCK_MODE=1):
  - load[1] asserted alone with ch1=8'h22 → data_out=8'h22, state HELD(1);
  - then load[0] also asserted with ch0=8'hFF → data_out stays 8'h22, conflict=1;
  - drop load[1] → next cycle data_out=8'hFF, src=0.
- Increment wrap: data_out=8'hFF, inc=1, carry_in=1 → data_out=8'h00, carry_out=1. Next cycle inc=0 → carry_out=0.
- Chained 16-bit PC from 16'h12FF with low half inc, carry_in=1 → cycle 1: 16'h1200; cycle 2: 16'h1300. Decrement from 16'h1300 yields borrow to 16'h12FF over two cycles.
- Precedence: load[0]=1 with inc=1 and data 8'h40 → data_out=8'h40, carry_out=0. Then inc=dec=1 → data_out holds 8'h40, conflict=1.

Source files
------------

// File: rtl/reg_multi_pkg.sv
// rtl/reg_multi_pkg.sv - shared types and helpers for multi-source datapath registers
//
// Contents:
//   arb_state_t        arbiter state for lock-on-first ownership (IDLE / HELD)
//   MAX_IN, IDX_W      widest request vector the helper accepts, and its index width
//   lsi_t              {found, index} result of a lowest-set-bit search
//   lowest_set_index   returns the lowest asserted bit position of a request vector
package reg_multi_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HELD = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_IN = 32;
    localparam int unsigned IDX_W  = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
    } lsi_t;

    // Walk from the top down so the last hit, i.e. the lowest index, wins.
    function automatic lsi_t lowest_set_index(input logic [MAX_IN-1:0] vec);
        lsi_t r;
        r.found = 1'b0;
        r.index = '0;
        for (int i = MAX_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.index = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_onehot.sv
// rtl/prio_onehot.sv - lowest-index-first priority encoder with one-hot grant
//
// Parameters:
//   NUM_IN  number of request lines (>= 1)
//   SRC_W   width of the encoded index, $clog2(NUM_IN) with a minimum of 1
// Ports:
//   req    in   NUM_IN  request vector, bit 0 has the highest priority
//   grant  out  NUM_IN  one-hot grant of the lowest asserted request (zero if none)
//   index  out  SRC_W   binary index of the granted request (zero if none)
//   any    out  1       at least one request asserted
module prio_onehot #(
    parameter int NUM_IN = 2,
    parameter int SRC_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic [NUM_IN-1:0] req,
    output logic [NUM_IN-1:0] grant,
    output logic [SRC_W-1:0]  index,
    output logic              any
);

    // Two's-complement trick: req & -req isolates the lowest set bit.
    assign grant = req & (~req + NUM_IN'(1));
    assign any   = |req;

    always_comb begin
        index = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/register_multi_in.sv
// rtl/register_multi_in.sv - multi-source register with priority/lock arbitration and inc/dec
//
// Parameters:
//   WIDTH        data width
//   NUM_IN       number of input channels (>= 1)
//   LOCK_MODE    0 = fixed priority every cycle, 1 = first winner holds until it releases
//   RESET_VALUE  data_out after reset
//   SRC_W        channel index width, derived
// Ports:
//   clk             in   1             system clock, rising edge
//   rst_n           in   1             synchronous active-low reset
//   data_in         in   NUM_IN*WIDTH  channel k at [k*WIDTH +: WIDTH]
//   load            in   NUM_IN        per-channel load request
//   inc             in   1             add carry_in when no load wins
//   dec             in   1             subtract carry_in when no load wins
//   carry_in        in   1             inc/dec amount, chained from the lower half
//   clear_conflict  in   1             clears the sticky conflict flag
//   data_out        out  WIDTH         register contents
//   carry_out       out  1             carry/borrow of the last inc/dec
//   src             out  SRC_W         channel of the last load
//   valid           out  1             a load has happened since reset
//   conflict        out  1             sticky arbitration/command conflict
module register_multi_in
    import reg_multi_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               NUM_IN      = 2,
    parameter int               LOCK_MODE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SRC_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic [NUM_IN-1:0]       load,
    input  logic                    inc,
    input  logic                    dec,
    input  logic                    carry_in,
    input  logic                    clear_conflict,
    output logic [WIDTH-1:0]        data_out,
    output logic                    carry_out,
    output logic [SRC_W-1:0]        src,
    output logic                    valid,
    output logic                    conflict
);

    logic [NUM_IN-1:0] grant;
    logic [SRC_W-1:0]  win_idx;
    logic              win_any;

    prio_onehot #(
        .NUM_IN (NUM_IN),
        .SRC_W  (SRC_W)
    ) u_prio (
        .req   (load),
        .grant (grant),
        .index (win_idx),
        .any   (win_any)
    );

    arb_state_t        state;
    logic [NUM_IN-1:0] owner;   // one-hot owner while HELD, zero otherwise

    logic              owner_active;
    logic [NUM_IN-1:0] sel_oh;
    logic [SRC_W-1:0]  sel_idx;
    logic              do_load;
    logic [WIDTH-1:0]  cap_data;
    logic              ignored_load;
    logic              multi_load;
    logic              conflict_set;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;

    // An owner that drops its load gives up ownership in that same cycle,
    // so the remaining loads arbitrate as if the arbiter were idle.
    assign owner_active = (LOCK_MODE != 0) && (state == ARB_HELD) && (|(load & owner));

    always_comb begin
        sel_oh  = grant;
        sel_idx = win_idx;
        do_load = win_any;
        if (owner_active) begin
            sel_oh  = owner;
            sel_idx = src;      // src always names the owner while HELD
            do_load = 1'b1;
        end
    end

    always_comb begin
        cap_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_oh[k]) begin
                cap_data = cap_data | data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign ignored_load = owner_active && (|(load & ~owner));
    // load & (load - 1) clears the lowest set bit; anything left means two or more.
    assign multi_load   = (LOCK_MODE == 0) && (|(load & (load - NUM_IN'(1))));
    assign conflict_set = ignored_load | multi_load | (inc & dec);

    // One extra bit catches the carry on inc and the borrow on dec.
    assign sum  = {1'b0, data_out} + {{WIDTH{1'b0}}, carry_in};
    assign diff = {1'b0, data_out} - {{WIDTH{1'b0}}, carry_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out  <= RESET_VALUE;
            carry_out <= 1'b0;
            src       <= '0;
            valid     <= 1'b0;
            conflict  <= 1'b0;
            state     <= ARB_IDLE;
            owner     <= '0;
        end else begin
            if (do_load) begin
                data_out  <= cap_data;
                src       <= sel_idx;
                valid     <= 1'b1;
                carry_out <= 1'b0;
            end else if (inc && !dec) begin
                {carry_out, data_out} <= sum;
            end else if (dec && !inc) begin
                {carry_out, data_out} <= diff;
            end else begin
                carry_out <= 1'b0;
            end

            if ((LOCK_MODE != 0) && do_load) begin
                state <= ARB_HELD;
                owner <= sel_oh;
            end else begin
                state <= ARB_IDLE;
                owner <= '0;
            end

            conflict <= conflict_set | (conflict & ~clear_conflict);
        end
    end

endmodule

// File: tb/tb_register_multi_in.sv
// tb/tb_register_multi_in.sv - self-checking bench for register_multi_in
module tb_register_multi_in;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic [1:0] src;
        logic       v;
        logic       conf;
        logic       held;
        logic [1:0] owner;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  load;
    logic [31:0] din;
    logic        inc, dec, cin, clr;

    logic [7:0]  q0, q1;
    logic        c0, c1, v0, v1, f0, f1;
    logic [1:0]  s0, s1;

    logic        pc_rst_n, pc_clr;
    logic [1:0]  pc_load;
    logic [15:0] lo_din, hi_din;
    logic        lo_inc, lo_dec, hi_inc, hi_dec;
    logic [7:0]  lo_q, hi_q;
    logic        lo_c, hi_c, lo_v, hi_v, lo_f, hi_f;
    logic [0:0]  lo_s, hi_s;

    int checks = 0;
    int fails  = 0;
    mdl_t m0, m1;

    always #5 clk = ~clk;

    register_multi_in #(.WIDTH(8), .NUM_IN(4), .LOCK_MODE(0), .RESET_VALUE(8'hA5)) u_fix (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load(load), .inc(inc), .dec(dec),
        .carry_in(cin), .clear_conflict(clr), .data_out(q0), .carry_out(c0), .src(s0),
        .valid(v0), .conflict(f0));

    register_multi_in #(.WIDTH(8), .NUM_IN(4), .LOCK_MODE(1), .RESET_VALUE(8'h00)) u_lock (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load(load), .inc(inc), .dec(dec),
        .carry_in(cin), .clear_conflict(clr), .data_out(q1), .carry_out(c1), .src(s1),
        .valid(v1), .conflict(f1));

    register_multi_in #(.WIDTH(8), .NUM_IN(2), .LOCK_MODE(0)) u_pc_lo (
        .clk(clk), .rst_n(pc_rst_n), .data_in(lo_din), .load(pc_load), .inc(lo_inc), .dec(lo_dec),
        .carry_in(1'b1), .clear_conflict(pc_clr), .data_out(lo_q), .carry_out(lo_c), .src(lo_s),
        .valid(lo_v), .conflict(lo_f));

    register_multi_in #(.WIDTH(8), .NUM_IN(2), .LOCK_MODE(0)) u_pc_hi (
        .clk(clk), .rst_n(pc_rst_n), .data_in(hi_din), .load(pc_load), .inc(hi_inc), .dec(hi_dec),
        .carry_in(lo_c), .clear_conflict(pc_clr), .data_out(hi_q), .carry_out(hi_c), .src(hi_s),
        .valid(hi_v), .conflict(hi_f));

    function automatic mdl_t model_reset(input logic [7:0] rv);
        mdl_t r;
        r = '0;
        r.d = rv;
        return r;
    endfunction

    // Next state from the behavioural rules: who wins, what is captured, what flags.
    function automatic mdl_t model_next(input mdl_t m, input bit lock, input logic [3:0] ld,
                                        input logic [31:0] dv, input bit i_inc, input bit i_dec,
                                        input bit i_cin, input bit i_clr);
        mdl_t n;
        int   w;
        int   t;
        bit   ign;
        n   = m;
        w   = -1;
        ign = 1'b0;
        if (lock && m.held && ld[m.owner]) begin
            w   = int'(m.owner);
            ign = (ld & ~(4'b0001 << m.owner)) != 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) if (ld[i] && w < 0) w = i;
        end
        if (w >= 0) begin
            n.d     = dv[w*8 +: 8];
            n.c     = 1'b0;
            n.src   = w[1:0];
            n.v     = 1'b1;
            n.held  = lock;
            n.owner = w[1:0];
        end else begin
            n.held  = 1'b0;
            n.owner = 2'd0;
            if (i_inc && !i_dec) begin
                t   = int'(m.d) + int'(i_cin);
                n.d = t[7:0];
                n.c = t > 255;
            end else if (i_dec && !i_inc) begin
                t   = int'(m.d) - int'(i_cin);
                n.d = t[7:0];
                n.c = t < 0;
            end else begin
                n.c = 1'b0;
            end
        end
        if ((!lock && $countones(ld) >= 2) || ign || (i_inc && i_dec)) n.conf = 1'b1;
        else if (i_clr) n.conf = 1'b0;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m0 = model_reset(8'hA5);
            m1 = model_reset(8'h00);
        end else begin
            m0 = model_next(m0, 1'b0, load, din, inc, dec, cin, clr);
            m1 = model_next(m1, 1'b1, load, din, inc, dec, cin, clr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 4'b1111; din = 32'hDEADBEEF; inc = 1'b1; dec = 1'b0; cin = 1'b1; clr = 1'b0;
        step(); step();
        checks++; if (q0 !== 8'hA5) begin fails++; $display("FAIL reset_data got %h exp a5", q0); end
        checks++; if (v0 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", v0); end
        checks++; if (f0 !== 1'b0) begin fails++; $display("FAIL reset_conflict got %b exp 0", f0); end
        checks++; if (q1 !== 8'h00) begin fails++; $display("FAIL reset_data_lock got %h exp 00", q1); end
        rst_n = 1'b1; load = 4'b0010; din = 32'h00003C00; inc = 1'b0;
        step();
        checks++; if (q0 !== 8'h3C) begin fails++; $display("FAIL release_data got %h exp 3c", q0); end
        checks++; if (s0 !== 2'd1) begin fails++; $display("FAIL release_src got %0d exp 1", s0); end
        checks++; if (v0 !== 1'b1) begin fails++; $display("FAIL release_valid got %b exp 1", v0); end
    endtask

    task automatic test_priority();
        load = 4'b1010; din = 32'h33001100;
        step();
        checks++; if (q0 !== 8'h11) begin fails++; $display("FAIL prio_data got %h exp 11", q0); end
        checks++; if (s0 !== 2'd1) begin fails++; $display("FAIL prio_src got %0d exp 1", s0); end
        checks++; if (f0 !== 1'b1) begin fails++; $display("FAIL prio_conflict got %b exp 1", f0); end
        load = 4'b0000; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (f0 !== 1'b0) begin fails++; $display("FAIL prio_clear got %b exp 0", f0); end
    endtask

    task automatic test_lock();
        load = 4'b0010; din = 32'h00002200;
        step();
        checks++; if (q1 !== 8'h22) begin fails++; $display("FAIL lock_take got %h exp 22", q1); end
        checks++; if (f1 !== 1'b0) begin fails++; $display("FAIL lock_take_conflict got %b exp 0", f1); end
        load = 4'b0011; din = 32'h000022FF;
        step();
        checks++; if (q1 !== 8'h22) begin fails++; $display("FAIL lock_hold got %h exp 22", q1); end
        checks++; if (f1 !== 1'b1) begin fails++; $display("FAIL lock_conflict got %b exp 1", f1); end
        load = 4'b0001;
        step();
        checks++; if (q1 !== 8'hFF) begin fails++; $display("FAIL lock_release got %h exp ff", q1); end
        checks++; if (s1 !== 2'd0) begin fails++; $display("FAIL lock_release_src got %0d exp 0", s1); end
        // Reset while HELD(1): the first post-reset cycle must arbitrate from idle.
        load = 4'b0010; din = 32'h00007700;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; load = 4'b0011; din = 32'h00007766;
        step();
        checks++; if (q1 !== 8'h66) begin fails++; $display("FAIL lock_reset_idle got %h exp 66", q1); end
        load = 4'b0000; clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_inc_wrap();
        load = 4'b0001; din = 32'h000000FF;
        step();
        load = 4'b0000; inc = 1'b1; cin = 1'b1;
        step();
        checks++; if (q0 !== 8'h00) begin fails++; $display("FAIL wrap_data got %h exp 00", q0); end
        checks++; if (c0 !== 1'b1) begin fails++; $display("FAIL wrap_carry got %b exp 1", c0); end
        inc = 1'b0;
        step();
        checks++; if (c0 !== 1'b0) begin fails++; $display("FAIL wrap_carry_clear got %b exp 0", c0); end
    endtask

    task automatic test_precedence();
        load = 4'b0001; din = 32'h00000040; inc = 1'b1; cin = 1'b1;
        step();
        checks++; if (q0 !== 8'h40) begin fails++; $display("FAIL prec_load got %h exp 40", q0); end
        checks++; if (c0 !== 1'b0) begin fails++; $display("FAIL prec_carry got %b exp 0", c0); end
        load = 4'b0000; inc = 1'b1; dec = 1'b1;
        step();
        checks++; if (q0 !== 8'h40) begin fails++; $display("FAIL prec_hold got %h exp 40", q0); end
        checks++; if (f0 !== 1'b1) begin fails++; $display("FAIL prec_conflict got %b exp 1", f0); end
        inc = 1'b0; dec = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_pc_chain();
        pc_rst_n = 1'b0;
        step();
        pc_rst_n = 1'b1; pc_load = 2'b01; lo_din = 16'h00FF; hi_din = 16'h0012;
        step();
        checks++; if ({hi_q, lo_q} !== 16'h12FF) begin fails++; $display("FAIL pc_load got %h exp 12ff", {hi_q, lo_q}); end
        pc_load = 2'b00; lo_inc = 1'b1; hi_inc = 1'b1;
        step();
        checks++; if ({hi_q, lo_q} !== 16'h1200) begin fails++; $display("FAIL pc_inc1 got %h exp 1200", {hi_q, lo_q}); end
        checks++; if (lo_c !== 1'b1) begin fails++; $display("FAIL pc_inc_carry got %b exp 1", lo_c); end
        lo_inc = 1'b0;
        step();
        checks++; if ({hi_q, lo_q} !== 16'h1300) begin fails++; $display("FAIL pc_inc2 got %h exp 1300", {hi_q, lo_q}); end
        hi_inc = 1'b0; lo_dec = 1'b1; hi_dec = 1'b1;
        step();
        checks++; if ({hi_q, lo_q} !== 16'h13FF) begin fails++; $display("FAIL pc_dec1 got %h exp 13ff", {hi_q, lo_q}); end
        checks++; if (lo_c !== 1'b1) begin fails++; $display("FAIL pc_borrow got %b exp 1", lo_c); end
        lo_dec = 1'b0;
        step();
        checks++; if ({hi_q, lo_q} !== 16'h12FF) begin fails++; $display("FAIL pc_dec2 got %h exp 12ff", {hi_q, lo_q}); end
        checks++; if (hi_f !== 1'b0) begin fails++; $display("FAIL pc_conflict got %b exp 0", hi_f); end
        hi_dec = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            load  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            din   = $urandom;
            inc   = ($urandom_range(0, 2) == 0);
            dec   = ($urandom_range(0, 3) == 0);
            cin   = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            step();
            checks++; if (q0 !== m0.d) begin fails++; $display("FAIL rnd_fix_data n=%0d got %h exp %h", n, q0, m0.d); end
            checks++; if (c0 !== m0.c) begin fails++; $display("FAIL rnd_fix_carry n=%0d got %b exp %b", n, c0, m0.c); end
            checks++; if (s0 !== m0.src) begin fails++; $display("FAIL rnd_fix_src n=%0d got %0d exp %0d", n, s0, m0.src); end
            checks++; if (v0 !== m0.v) begin fails++; $display("FAIL rnd_fix_valid n=%0d got %b exp %b", n, v0, m0.v); end
            checks++; if (f0 !== m0.conf) begin fails++; $display("FAIL rnd_fix_conflict n=%0d got %b exp %b", n, f0, m0.conf); end
            checks++; if (q1 !== m1.d) begin fails++; $display("FAIL rnd_lock_data n=%0d got %h exp %h", n, q1, m1.d); end
            checks++; if (c1 !== m1.c) begin fails++; $display("FAIL rnd_lock_carry n=%0d got %b exp %b", n, c1, m1.c); end
            checks++; if (s1 !== m1.src) begin fails++; $display("FAIL rnd_lock_src n=%0d got %0d exp %0d", n, s1, m1.src); end
            checks++; if (v1 !== m1.v) begin fails++; $display("FAIL rnd_lock_valid n=%0d got %b exp %b", n, v1, m1.v); end
            checks++; if (f1 !== m1.conf) begin fails++; $display("FAIL rnd_lock_conflict n=%0d got %b exp %b", n, f1, m1.conf); end
        end
    endtask

    initial begin
        rst_n = 1'b0; load = '0; din = '0; inc = 1'b0; dec = 1'b0; cin = 1'b0; clr = 1'b0;
        pc_rst_n = 1'b0; pc_clr = 1'b0; pc_load = '0; lo_din = '0; hi_din = '0;
        lo_inc = 1'b0; lo_dec = 1'b0; hi_inc = 1'b0; hi_dec = 1'b0;
        m0 = model_reset(8'hA5);
        m1 = model_reset(8'h00);
        test_reset();
        test_priority();
        test_lock();
        test_inc_wrap();
        test_precedence();
        test_pc_chain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
